// File: rtl/reg_write_sequencer_if.sv
// ---------------------------------------------------------------------------
// reg_write_sequencer_if
//   Command handshake between the control unit and the register write
//   sequencer. One command is transferred on a clock edge where both
//   cmd_valid and cmd_ready are high.
//
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  sequencer idle and able to accept
//   cmd_clr    master->slave  "clear all registers" (other fields ignored)
//   cmd_wb     master->slave  write ALU result back to cmd_dst
//   cmd_src_a  master->slave  ALU operand A register index
//   cmd_src_b  master->slave  ALU operand B register index
//   cmd_dst    master->slave  destination register index
// ---------------------------------------------------------------------------
interface reg_write_sequencer_if #(
   parameter int NUM_REGS = 4
);
   localparam int SEL_W = $clog2(NUM_REGS);

   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_clr;
   logic             cmd_wb;
   logic [SEL_W-1:0] cmd_src_a;
   logic [SEL_W-1:0] cmd_src_b;
   logic [SEL_W-1:0] cmd_dst;

   modport master (
      output cmd_valid, cmd_clr, cmd_wb, cmd_src_a, cmd_src_b, cmd_dst,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_clr, cmd_wb, cmd_src_a, cmd_src_b, cmd_dst,
      output cmd_ready
   );
endinterface

// File: rtl/reg_write_sequencer.sv
// ---------------------------------------------------------------------------
// reg_write_sequencer
//   Multi-cycle controller sequencing the register bank around the ALU.
//   An ALU command walks READ -> EXEC (ALU_LAT cycles) -> WRITE -> DONE;
//   a clear command walks CLEAR -> DONE. One command in flight at a time.
//
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   cmd        command handshake (slave side)
//   rd_sel_a   read-mux select A, held from READ through WRITE
//   rd_sel_b   read-mux select B, held from READ through WRITE
//   alu_start  one-cycle pulse on the first EXEC cycle
//   save       one-hot (or zero) save strobe in WRITE
//   reg_clr    one-cycle clear strobe to all registers
//   done       one-cycle completion pulse
//   err        with done: write-back requested to an index >= NUM_REGS
// ---------------------------------------------------------------------------
module reg_write_sequencer #(
   parameter int NUM_REGS = 4,
   parameter int ALU_LAT  = 1,
   localparam int SEL_W   = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                reset,
   reg_write_sequencer_if.slave cmd,
   output logic [SEL_W-1:0]    rd_sel_a,
   output logic [SEL_W-1:0]    rd_sel_b,
   output logic                alu_start,
   output logic [NUM_REGS-1:0] save,
   output logic                reg_clr,
   output logic                done,
   output logic                err
);

   // Counter only has to hold ALU_LAT-1.
   localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      READ,
      EXEC,
      WRITE,
      DONE
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic [SEL_W-1:0] src_a_q, src_b_q, dst_q;
   logic             wb_q;
   logic             accept;
   logic             dst_ok;

   assign accept = cmd.cmd_valid && (state == IDLE);
   assign dst_ok = int'(dst_q) < NUM_REGS;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         src_a_q <= '0;
         src_b_q <= '0;
         dst_q   <= '0;
         wb_q    <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (accept) begin
            src_a_q <= cmd.cmd_src_a;
            src_b_q <= cmd.cmd_src_b;
            dst_q   <= cmd.cmd_dst;
            // A clear never writes back, so it can never flag err.
            wb_q    <= cmd.cmd_wb & ~cmd.cmd_clr;
         end
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case leaves a signal unassigned and no latch is inferred.
      state_next    = state;
      cnt_next      = cnt;
      cmd.cmd_ready = (state == IDLE);
      rd_sel_a      = '0;
      rd_sel_b      = '0;
      alu_start     = 1'b0;
      save          = '0;
      reg_clr       = 1'b0;
      done          = 1'b0;
      err           = 1'b0;

      case (state)
         IDLE: begin
            if (accept) state_next = cmd.cmd_clr ? CLEAR : READ;
         end
         CLEAR: begin
            reg_clr    = 1'b1;
            state_next = DONE;
         end
         READ: begin
            rd_sel_a   = src_a_q;
            rd_sel_b   = src_b_q;
            cnt_next   = CNT_W'(ALU_LAT - 1);
            state_next = EXEC;
         end
         EXEC: begin
            rd_sel_a = src_a_q;
            rd_sel_b = src_b_q;
            // The counter is freshly loaded on the first EXEC cycle only.
            alu_start = (cnt == CNT_W'(ALU_LAT - 1));
            if (cnt == '0) state_next = WRITE;
            else           cnt_next   = cnt - CNT_W'(1);
         end
         WRITE: begin
            rd_sel_a = src_a_q;
            rd_sel_b = src_b_q;
            if (wb_q && dst_ok) save = NUM_REGS'(1) << dst_q;
            state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            err        = wb_q && !dst_ok;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // Reset takes effect at once on the strobes so an aborted command
      // never emits a partial pulse.
      if (reset) begin
         rd_sel_a  = '0;
         rd_sel_b  = '0;
         alu_start = 1'b0;
         save      = '0;
         reg_clr   = 1'b0;
         done      = 1'b0;
         err       = 1'b0;
      end
   end

endmodule

// File: tb/tb_reg_write_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reg_write_sequencer
//   Directed bench for reg_write_sequencer: a 4-register instance with
//   ALU_LAT=1 and a 3-register instance for out-of-range destinations.
//   Inputs change and outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_reg_write_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int pulses;

   // 4-register instance
   reg_write_sequencer_if #(.NUM_REGS(4)) if4 ();
   logic [1:0] rd_sel_a4, rd_sel_b4;
   logic       alu_start4, reg_clr4, done4, err4;
   logic [3:0] save4;

   reg_write_sequencer #(.NUM_REGS(4), .ALU_LAT(1)) dut4 (
      .clk(clk), .reset(reset), .cmd(if4.slave),
      .rd_sel_a(rd_sel_a4), .rd_sel_b(rd_sel_b4), .alu_start(alu_start4),
      .save(save4), .reg_clr(reg_clr4), .done(done4), .err(err4)
   );

   // 3-register instance
   reg_write_sequencer_if #(.NUM_REGS(3)) if3 ();
   logic [1:0] rd_sel_a3, rd_sel_b3;
   logic       alu_start3, reg_clr3, done3, err3;
   logic [2:0] save3;

   reg_write_sequencer #(.NUM_REGS(3), .ALU_LAT(1)) dut3 (
      .clk(clk), .reset(reset), .cmd(if3.slave),
      .rd_sel_a(rd_sel_a3), .rd_sel_b(rd_sel_b3), .alu_start(alu_start3),
      .save(save3), .reg_clr(reg_clr3), .done(done3), .err(err3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command to the 4-register instance (which is idle) and
   // return in cycle N+1, valid already dropped.
   task automatic send4(input logic clr, input logic wb, input logic [1:0] a,
                        input logic [1:0] b, input logic [1:0] d);
      if4.cmd_clr = clr; if4.cmd_wb = wb;
      if4.cmd_src_a = a; if4.cmd_src_b = b; if4.cmd_dst = d;
      if4.cmd_valid = 1'b1;
      tick();
      if4.cmd_valid = 1'b0;
   endtask

   task automatic send3(input logic wb, input logic [1:0] d);
      if3.cmd_clr = 1'b0; if3.cmd_wb = wb;
      if3.cmd_src_a = 2'd0; if3.cmd_src_b = 2'd1; if3.cmd_dst = d;
      if3.cmd_valid = 1'b1;
      tick();
      if3.cmd_valid = 1'b0;
   endtask

   initial begin
      if4.cmd_valid = 1'b0; if4.cmd_clr = 1'b0; if4.cmd_wb = 1'b0;
      if4.cmd_src_a = '0; if4.cmd_src_b = '0; if4.cmd_dst = '0;
      if3.cmd_valid = 1'b0; if3.cmd_clr = 1'b0; if3.cmd_wb = 1'b0;
      if3.cmd_src_a = '0; if3.cmd_src_b = '0; if3.cmd_dst = '0;

      // 1. reset held for two cycles, then idle
      tick(); tick();
      reset = 1'b0;
      check("rst_ready", if4.cmd_ready, 1);
      check("rst_save", save4, 0);
      check("rst_done", done4, 0);
      check("rst_alu_start", alu_start4, 0);
      check("rst_reg_clr", reg_clr4, 0);
      check("rst_rd_sel_a", rd_sel_a4, 0);
      check("rst_ready3", if3.cmd_ready, 1);
      tick();

      // 2. ALU op: a=1 b=2 dst=3 wb=1
      send4(1'b0, 1'b1, 2'd1, 2'd2, 2'd3);           // N+1 READ
      check("op_n1_ready", if4.cmd_ready, 0);
      check("op_n1_alu_start", alu_start4, 0);
      check("op_n1_sel_a", rd_sel_a4, 1);
      check("op_n1_sel_b", rd_sel_b4, 2);
      tick();                                        // N+2 EXEC
      check("op_n2_alu_start", alu_start4, 1);
      check("op_n2_save", save4, 0);
      check("op_n2_sel_a", rd_sel_a4, 1);
      check("op_n2_sel_b", rd_sel_b4, 2);
      tick();                                        // N+3 WRITE
      check("op_n3_alu_start", alu_start4, 0);
      check("op_n3_save", save4, 4'b1000);
      check("op_n3_sel_a", rd_sel_a4, 1);
      check("op_n3_sel_b", rd_sel_b4, 2);
      tick();                                        // N+4 DONE
      check("op_n4_done", done4, 1);
      check("op_n4_err", err4, 0);
      check("op_n4_save", save4, 0);
      check("op_n4_ready", if4.cmd_ready, 0);
      tick();                                        // N+5 IDLE
      check("op_n5_ready", if4.cmd_ready, 1);
      check("op_n5_done", done4, 0);

      // 3. clear with non-zero fields that must be ignored
      send4(1'b1, 1'b1, 2'd2, 2'd3, 2'd1);           // N+1 CLEAR
      check("clr_n1_reg_clr", reg_clr4, 1);
      check("clr_n1_save", save4, 0);
      check("clr_n1_alu_start", alu_start4, 0);
      tick();                                        // N+2 DONE
      check("clr_n2_reg_clr", reg_clr4, 0);
      check("clr_n2_done", done4, 1);
      check("clr_n2_err", err4, 0);
      check("clr_n2_save", save4, 0);
      tick();                                        // N+3 IDLE
      check("clr_n3_ready", if4.cmd_ready, 1);
      check("clr_n3_done", done4, 0);

      // 4. second command presented while busy
      send4(1'b0, 1'b1, 2'd0, 2'd0, 2'd1);           // N+1
      pulses = (save4 != 0) ? 1 : 0;
      tick();                                        // N+2 EXEC
      if4.cmd_src_a = 2'd3; if4.cmd_src_b = 2'd3; if4.cmd_dst = 2'd2;
      if4.cmd_wb = 1'b1; if4.cmd_clr = 1'b0; if4.cmd_valid = 1'b1;
      check("busy_n2_ready", if4.cmd_ready, 0);
      check("busy_n2_sel_a", rd_sel_a4, 0);
      pulses += (save4 != 0) ? 1 : 0;
      tick();                                        // N+3 WRITE
      check("busy_n3_save", save4, 4'b0010);
      pulses += (save4 != 0) ? 1 : 0;
      tick();                                        // N+4 DONE
      check("busy_n4_ready", if4.cmd_ready, 0);
      pulses += (save4 != 0) ? 1 : 0;
      tick();                                        // N+5 IDLE, accepted at next edge
      check("busy_n5_ready", if4.cmd_ready, 1);
      pulses += (save4 != 0) ? 1 : 0;
      check("busy_one_save", pulses, 1);
      tick();                                        // READ of second command
      if4.cmd_valid = 1'b0;
      check("busy2_ready", if4.cmd_ready, 0);
      check("busy2_sel_a", rd_sel_a4, 3);
      tick();                                        // EXEC
      check("busy2_alu_start", alu_start4, 1);
      tick();                                        // WRITE
      check("busy2_save", save4, 4'b0100);
      tick();                                        // DONE
      check("busy2_done", done4, 1);
      tick();

      // 5. reset during EXEC
      send4(1'b0, 1'b1, 2'd1, 2'd2, 2'd0);           // N+1 READ
      tick();                                        // N+2 EXEC
      check("rmid_alu_start", alu_start4, 1);
      reset = 1'b1;
      #1;
      check("rmid_save_in_reset", save4, 0);
      check("rmid_alu_start_gated", alu_start4, 0);
      tick();                                        // N+3 IDLE
      reset = 1'b0;
      check("rmid_ready", if4.cmd_ready, 1);
      check("rmid_save", save4, 0);
      check("rmid_done", done4, 0);
      tick();
      check("rmid_save_after", save4, 0);
      check("rmid_done_after", done4, 0);

      // 6. NUM_REGS=3, dst=3 out of range
      send3(1'b1, 2'd3);                             // N+1 READ
      tick();                                        // N+2 EXEC
      tick();                                        // N+3 WRITE
      check("oor_wb_save", save3, 0);
      tick();                                        // N+4 DONE
      check("oor_wb_done", done3, 1);
      check("oor_wb_err", err3, 1);
      tick();
      check("oor_wb_ready", if3.cmd_ready, 1);

      send3(1'b0, 2'd3);
      tick(); tick();
      check("oor_nowb_save", save3, 0);
      tick();
      check("oor_nowb_done", done3, 1);
      check("oor_nowb_err", err3, 0);
      tick();

      // in-range write on the 3-register instance
      send3(1'b1, 2'd2);
      tick(); tick();
      check("n3_save", save3, 3'b100);
      tick();
      check("n3_err", err3, 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
